// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of the 8x8 combinational ROM.
// Holds the PC, captures ROM bytes into an instruction register and hands
// them to decode over a valid/ready handshake. Supports jump redirect with
// flush, level-sensitive halt and a delivered-instruction counter.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | first cycle after reset; no fetch, jump may preload pc
// RUN   | fetching one instruction per cycle whenever the slot is free
// HALT  | fetch stopped; held instruction may still be consumed
module fetch_unit (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       jump_en,
    input  logic [2:0] jump_addr,
    input  logic       halt,
    output logic [7:0] instr,
    output logic [2:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       wrap,
    output logic [7:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] pc;
    logic       slot_free;
    logic       handshake;
    logic       do_fetch;
    logic       do_jump;
    logic       do_drop;

    assign rom_addr  = pc;
    assign slot_free = !instr_valid || instr_ready;
    assign handshake = instr_valid && instr_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle action select; jump outranks halt and fetch.
    always_comb begin
        state_nxt = state;
        do_fetch  = 1'b0;
        do_jump   = 1'b0;
        do_drop   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = RUN;
                do_jump   = jump_en;
            end
            RUN: begin
                if (halt) state_nxt = HALT;
                if (jump_en)        do_jump  = 1'b1;
                else if (halt)      do_drop  = handshake;
                else if (slot_free) do_fetch = 1'b1;
            end
            HALT: begin
                if (!halt) state_nxt = RUN;
                if (jump_en) do_jump = 1'b1;
                else         do_drop = handshake;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: pc, instruction register, wrap pulse and handshake counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= 3'd0;
            instr       <= 8'd0;
            instr_pc    <= 3'd0;
            instr_valid <= 1'b0;
            wrap        <= 1'b0;
            fetch_count <= 8'd0;
        end else begin
            wrap <= do_fetch && (pc == 3'd7);
            if (handshake) fetch_count <= fetch_count + 8'd1;
            if (do_jump) begin
                // The flush also drops an instruction stalled by decode.
                pc          <= jump_addr;
                instr_valid <= 1'b0;
            end else if (do_fetch) begin
                instr       <= rom_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 3'd1;
            end else if (do_drop) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
